// File: rtl/vc_inflight_pkg.sv
// ---------------------------------------------------------------------------
// vc_inflight_pkg
// Shared constants for the in-flight request / response-drop controller.
//   CNT_W   : width of the outstanding-request and pending-drop counters
//   STATS_W : width of the optional dropped-response statistics counter
// ---------------------------------------------------------------------------
package vc_inflight_pkg;

    localparam int CNT_W   = 8;
    localparam int STATS_W = 32;

endpackage

// File: rtl/vc_updown_counter.sv
// ---------------------------------------------------------------------------
// vc_updown_counter
// Up/down counter with a synchronous load. Load has priority over inc/dec.
// Simultaneous inc and dec leave the count unchanged. Decrement saturates at
// zero. Increment wraps, which suits a free-running statistics counter.
// Callers that must not wrap keep inc low at the top of their range.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset, clears the count
//   inc        : add one this cycle
//   dec        : subtract one this cycle (ignored at zero)
//   load       : replace the count with load_value
//   load_value : value taken when load is high
//   count      : registered count
// ---------------------------------------------------------------------------
module vc_updown_counter #(
    parameter int p_width = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    input  logic               load,
    input  logic [p_width-1:0] load_value,
    output logic [p_width-1:0] count
);

    logic [p_width-1:0] r_count;
    logic [p_width-1:0] w_next;

    always_comb begin
        w_next = r_count;
        if (load) begin
            w_next = load_value;
        end else if (inc && !dec) begin
            w_next = r_count + 1'b1;
        end else if (dec && !inc && (r_count != '0)) begin
            w_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/vc_inflight_drop_ctrl.sv
// ---------------------------------------------------------------------------
// vc_inflight_drop_ctrl
// Tracks memory requests issued by a pipeline and, after a squash, commands
// a downstream drop unit to discard the responses of every request that was
// outstanding when the squash happened.
//
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   squash       : pulse, discard responses of all outstanding requests
//   in_req_msg   : request message from the pipeline
//   in_req_val   : request valid from the pipeline
//   in_req_rdy   : request ready to the pipeline
//   out_req_msg  : request message to memory (pass-through)
//   out_req_val  : request valid to memory
//   out_req_rdy  : request ready from memory
//   resp_val     : response valid at the drop-unit input
//   resp_rdy     : response ready from the pipeline side
//   drop         : drop command for the current response
//   num_inflight : outstanding request count
//   num_dropped  : dropped-response count (only when the macro below is set)
//
// Build option: define VC_INFLIGHT_DROP_CTRL_STATS_EN to add num_dropped.
// ---------------------------------------------------------------------------
module vc_inflight_drop_ctrl
    import vc_inflight_pkg::*;
#(
    parameter int p_msg_nbits    = 32,
    parameter int p_max_inflight = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   squash,
    input  logic [p_msg_nbits-1:0] in_req_msg,
    input  logic                   in_req_val,
    output logic                   in_req_rdy,
    output logic [p_msg_nbits-1:0] out_req_msg,
    output logic                   out_req_val,
    input  logic                   out_req_rdy,
    input  logic                   resp_val,
    input  logic                   resp_rdy,
    output logic                   drop,
    output logic [CNT_W-1:0]       num_inflight
`ifdef VC_INFLIGHT_DROP_CTRL_STATS_EN
    ,
    output logic [STATS_W-1:0]     num_dropped
`endif
);

    logic             w_full;
    logic             w_req_go;
    logic             w_resp_done;
    logic [CNT_W-1:0] w_pending;
    logic [CNT_W-1:0] w_inflight_next;

    assign w_full      = (num_inflight == CNT_W'(p_max_inflight));

    // Handshakes are gated with reset so nothing is offered while it is low.
    assign out_req_msg = in_req_msg;
    assign out_req_val = reset && in_req_val && !w_full;
    assign in_req_rdy  = reset && out_req_rdy && !w_full;
    assign w_req_go    = out_req_val && out_req_rdy;

    // A squash drops the response arriving in the same cycle, even if no
    // earlier squash left anything pending.
    assign drop        = reset && resp_val && ((w_pending != '0) || squash);
    assign w_resp_done = resp_val && (drop || resp_rdy);

    // Next in-flight count, needed here as the squash load value; saturates
    // at zero when a response shows up with nothing outstanding.
    always_comb begin
        w_inflight_next = num_inflight;
        if (w_req_go && !w_resp_done) begin
            w_inflight_next = num_inflight + 1'b1;
        end else if (!w_req_go && w_resp_done && (num_inflight != '0)) begin
            w_inflight_next = num_inflight - 1'b1;
        end
    end

    vc_updown_counter #(
        .p_width (CNT_W)
    ) u_inflight (
        .clk        (clk),
        .reset      (reset),
        .inc        (w_req_go),
        .dec        (w_resp_done),
        .load       (1'b0),
        .load_value ('0),
        .count      (num_inflight)
    );

    // On squash every request still owed a response after this edge
    // (including one issued now, excluding one retiring now) must be dropped.
    // Reloading rather than adding keeps repeated squashes from stacking.
    vc_updown_counter #(
        .p_width (CNT_W)
    ) u_pending (
        .clk        (clk),
        .reset      (reset),
        .inc        (1'b0),
        .dec        (drop),
        .load       (squash),
        .load_value (w_inflight_next),
        .count      (w_pending)
    );

`ifdef VC_INFLIGHT_DROP_CTRL_STATS_EN
    vc_updown_counter #(
        .p_width (STATS_W)
    ) u_dropped (
        .clk        (clk),
        .reset      (reset),
        .inc        (drop),
        .dec        (1'b0),
        .load       (1'b0),
        .load_value ('0),
        .count      (num_dropped)
    );
`endif

endmodule

// File: tb/tb_vc_inflight_drop_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vc_inflight_drop_ctrl
// Directed stimulus with hand-computed expected outputs. The driver applies
// one input vector per cycle just after the rising edge and queues the
// expected outputs; the monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_vc_inflight_drop_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        squash = 1'b0;
    logic [31:0] in_req_msg = '0;
    logic        in_req_val = 1'b0;
    logic        in_req_rdy;
    logic [31:0] out_req_msg;
    logic        out_req_val;
    logic        out_req_rdy = 1'b0;
    logic        resp_val = 1'b0;
    logic        resp_rdy = 1'b0;
    logic        drop;
    logic [7:0]  num_inflight;
`ifdef VC_INFLIGHT_DROP_CTRL_STATS_EN
    logic [31:0] num_dropped;
    int unsigned nd_model = 0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        irdy;
        logic        oval;
        logic        drp;
        logic [7:0]  ninf;
        logic [31:0] msg;
        logic [31:0] nd;
        string       nm;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    vc_inflight_drop_ctrl #(
        .p_msg_nbits    (32),
        .p_max_inflight (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .squash       (squash),
        .in_req_msg   (in_req_msg),
        .in_req_val   (in_req_val),
        .in_req_rdy   (in_req_rdy),
        .out_req_msg  (out_req_msg),
        .out_req_val  (out_req_val),
        .out_req_rdy  (out_req_rdy),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .drop         (drop),
        .num_inflight (num_inflight)
`ifdef VC_INFLIGHT_DROP_CTRL_STATS_EN
        ,
        .num_dropped  (num_dropped)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, want);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.nm, ".in_req_rdy"},   32'(in_req_rdy),   32'(e.irdy));
            chk({e.nm, ".out_req_val"},  32'(out_req_val),  32'(e.oval));
            chk({e.nm, ".drop"},         32'(drop),         32'(e.drp));
            chk({e.nm, ".num_inflight"}, 32'(num_inflight), 32'(e.ninf));
            chk({e.nm, ".out_req_msg"},  out_req_msg,       e.msg);
`ifdef VC_INFLIGHT_DROP_CTRL_STATS_EN
            chk({e.nm, ".num_dropped"},  num_dropped,       e.nd);
`endif
        end
    end

    // Drive one cycle of inputs and queue the outputs expected that cycle.
    task automatic step(input string nm, input logic r, input logic iv, input logic ordy,
                        input logic sq, input logic rv, input logic rr,
                        input logic e_irdy, input logic e_oval, input logic e_drop,
                        input logic [7:0] e_ninf);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = r;
        in_req_val  = iv;
        out_req_rdy = ordy;
        squash      = sq;
        resp_val    = rv;
        resp_rdy    = rr;
        in_req_msg  = $urandom;
        e.irdy = e_irdy;
        e.oval = e_oval;
        e.drp  = e_drop;
        e.ninf = e_ninf;
        e.msg  = in_req_msg;
        e.nm   = nm;
        e.nd   = '0;
`ifdef VC_INFLIGHT_DROP_CTRL_STATS_EN
        if (!r) nd_model = 0;
        e.nd = nd_model;
        if (r && e_drop) nd_model++;
`endif
        exp_q.push_back(e);
    endtask

    initial begin
        //   name        rst iv ordy sq rv rr | irdy oval drop ninf
        // reset holds everything quiet even with requests and responses
        step("rst_a",     0, 1, 1,   0, 1, 1,   0,   0,   0,   0);
        step("rst_b",     0, 1, 1,   1, 1, 1,   0,   0,   0,   0);
        step("idle",      1, 0, 0,   0, 0, 0,   0,   0,   0,   0);
        // fill to the limit of 4, then hold off; no bypass of a retiring response
        step("fill0",     1, 1, 1,   0, 0, 0,   1,   1,   0,   0);
        step("fill1",     1, 1, 1,   0, 0, 0,   1,   1,   0,   1);
        step("fill2",     1, 1, 1,   0, 0, 0,   1,   1,   0,   2);
        step("fill3",     1, 1, 1,   0, 0, 0,   1,   1,   0,   3);
        step("full",      1, 1, 1,   0, 0, 0,   0,   0,   0,   4);
        step("full_rsp",  1, 1, 1,   0, 1, 1,   0,   0,   0,   4);
        step("reopen",    1, 0, 1,   0, 0, 0,   1,   0,   0,   3);
        // squash with 3 outstanding, then one post-squash request
        step("sq3",       1, 0, 0,   1, 0, 0,   0,   0,   0,   3);
        step("postreq",   1, 1, 1,   0, 0, 0,   1,   1,   0,   3);
        step("drop1",     1, 0, 0,   0, 1, 0,   0,   0,   1,   4);
        step("drop2",     1, 0, 0,   0, 1, 1,   0,   0,   1,   3);
        step("drop3",     1, 0, 0,   0, 1, 0,   0,   0,   1,   2);
        step("stall",     1, 0, 0,   0, 1, 0,   0,   0,   0,   1);
        step("keep",      1, 0, 0,   0, 1, 1,   0,   0,   0,   1);
        // squash coinciding with a retiring response and a new request
        step("req_a",     1, 1, 1,   0, 0, 0,   1,   1,   0,   0);
        step("req_b",     1, 1, 1,   0, 0, 0,   1,   1,   0,   1);
        step("sq_both",   1, 1, 1,   1, 1, 0,   1,   1,   1,   2);
        step("pd1",       1, 0, 0,   0, 1, 0,   0,   0,   1,   2);
        step("pd2",       1, 0, 0,   0, 1, 0,   0,   0,   1,   1);
        // stray response with nothing outstanding: no underflow
        step("rsp_empty", 1, 0, 0,   0, 1, 1,   0,   0,   0,   0);
        step("no_uflow",  1, 0, 0,   0, 0, 0,   0,   0,   0,   0);
        // back-to-back squash must not stack pending drops
        step("bb_req",    1, 1, 1,   0, 0, 0,   1,   1,   0,   0);
        step("bb_sq1",    1, 1, 1,   1, 0, 0,   1,   1,   0,   1);
        step("bb_sq2",    1, 0, 0,   1, 0, 0,   0,   0,   0,   2);
        step("bb_d1",     1, 0, 0,   0, 1, 0,   0,   0,   1,   2);
        step("bb_d2",     1, 0, 0,   0, 1, 0,   0,   0,   1,   1);
        step("bb_req2",   1, 1, 1,   0, 0, 0,   1,   1,   0,   0);
        step("bb_keep",   1, 0, 0,   0, 1, 0,   0,   0,   0,   1);
        step("bb_ret",    1, 0, 0,   0, 1, 1,   0,   0,   0,   1);
        // asynchronous reset with two pending drops
        step("ar_req1",   1, 1, 1,   0, 0, 0,   1,   1,   0,   0);
        step("ar_req2",   1, 1, 1,   0, 0, 0,   1,   1,   0,   1);
        step("ar_sq",     1, 0, 0,   1, 0, 0,   0,   0,   0,   2);
        step("ar_low",    0, 1, 1,   0, 1, 0,   0,   0,   0,   0);
        step("ar_rel",    1, 0, 0,   0, 0, 0,   0,   0,   0,   0);
        step("ar_rsp",    1, 0, 0,   0, 1, 0,   0,   0,   0,   0);
        step("ar_req3",   1, 1, 1,   0, 0, 0,   1,   1,   0,   0);
        step("ar_idle",   1, 0, 0,   0, 0, 0,   0,   0,   0,   1);

        // let the monitor drain, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
